// File: rtl/iob_asym_mem_streamer_pkg.sv
// Shared definitions for the asymmetric-width memory streamer: FSM encoding
// and lane-ratio helpers used to size the lane index.
package iob_asym_mem_streamer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_READ    = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_SERIAL  = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    localparam int DEF_MEM_DATA_W = 32;
    localparam int DEF_OUT_DATA_W = 8;

    // Number of narrow lanes packed in one memory word.
    function automatic int lane_ratio(input int mem_w, input int out_w);
        return mem_w / out_w;
    endfunction

    function automatic int lane_idx_w(input int ratio);
        return (ratio > 1) ? $clog2(ratio) : 1;
    endfunction

endpackage

// File: rtl/iob_asym_mem_streamer_reg_re.sv
// Register primitive with clock enable, synchronous reset and load enable;
// reset is honoured only on enabled clock cycles.
import iob_asym_mem_streamer_pkg::*;

module iob_reg_re #(
    parameter int                DATA_W  = 1,
    parameter logic [DATA_W-1:0] RST_VAL = '0
) (
    input  logic              clk_i,
    input  logic              cke_i,
    input  logic              rst_i,
    input  logic              en_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] data_o
);

    // Storage update: reset has priority over load.
    always_ff @(posedge clk_i) begin
        if (cke_i) begin
            if (rst_i) begin
                data_o <= RST_VAL;
            end else if (en_i) begin
                data_o <= data_i;
            end
        end
    end

endmodule

// File: rtl/iob_asym_mem_streamer.sv
// Reads wide words from a one-cycle-latency memory port and emits them as a
// narrow valid/ready stream, lane by lane, with a last-beat marker.
import iob_asym_mem_streamer_pkg::*;

module iob_asym_mem_streamer #(
    parameter int MEM_DATA_W = DEF_MEM_DATA_W,
    parameter int OUT_DATA_W = DEF_OUT_DATA_W,
    parameter int ADDR_W     = 10,
    parameter int LEN_W      = 16,
    parameter int BIG_ENDIAN = 0
) (
    input  logic                  clk_i,
    input  logic                  cke_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [ADDR_W-1:0]     base_addr_i,
    input  logic [LEN_W-1:0]      len_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  ext_mem_r_en_o,
    output logic [ADDR_W-1:0]     ext_mem_r_addr_o,
    input  logic [MEM_DATA_W-1:0] ext_mem_r_data_i,
    output logic                  m_valid_o,
    output logic [OUT_DATA_W-1:0] m_data_o,
    output logic                  m_last_o,
    input  logic                  m_ready_i
);

    localparam int R   = lane_ratio(MEM_DATA_W, OUT_DATA_W);
    localparam int R_W = lane_idx_w(R);

    localparam logic [R_W-1:0]    LANE_ZERO = R_W'(0);
    localparam logic [R_W-1:0]    LANE_ONE  = R_W'(1);
    localparam logic [R_W-1:0]    LANE_LAST = R_W'(R - 1);
    localparam logic [LEN_W-1:0]  LEN_ZERO  = LEN_W'(0);
    localparam logic [LEN_W-1:0]  LEN_ONE   = LEN_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

    state_t state_r;
    state_t state_s;

    logic [MEM_DATA_W-1:0] word_r;
    logic                  word_en_s;
    logic [ADDR_W-1:0]     addr_r;
    logic [ADDR_W-1:0]     addr_nxt_s;
    logic                  addr_en_s;
    logic [LEN_W-1:0]      rem_r;
    logic [LEN_W-1:0]      rem_nxt_s;
    logic                  rem_en_s;
    logic [LEN_W-1:0]      rem_d_s;
    logic [R_W-1:0]        lane_r;
    logic [R_W-1:0]        lane_nxt_s;
    logic                  lane_en_s;
    logic [R_W-1:0]        lane_sel_s;
    logic                  hs_s;

    iob_reg_re #(.DATA_W(MEM_DATA_W)) u_word_reg (
        .clk_i (clk_i),
        .cke_i (cke_i),
        .rst_i (rst_i),
        .en_i  (word_en_s),
        .data_i(ext_mem_r_data_i),
        .data_o(word_r)
    );

    iob_reg_re #(.DATA_W(ADDR_W)) u_addr_reg (
        .clk_i (clk_i),
        .cke_i (cke_i),
        .rst_i (rst_i),
        .en_i  (addr_en_s),
        .data_i(addr_nxt_s),
        .data_o(addr_r)
    );

    iob_reg_re #(.DATA_W(LEN_W)) u_rem_reg (
        .clk_i (clk_i),
        .cke_i (cke_i),
        .rst_i (rst_i),
        .en_i  (rem_en_s),
        .data_i(rem_nxt_s),
        .data_o(rem_r)
    );

    iob_reg_re #(.DATA_W(R_W)) u_lane_reg (
        .clk_i (clk_i),
        .cke_i (cke_i),
        .rst_i (rst_i),
        .en_i  (lane_en_s),
        .data_i(lane_nxt_s),
        .data_o(lane_r)
    );

    assign hs_s = (state_r == ST_SERIAL) & m_ready_i;

    // Next-state and datapath load control.
    always_comb begin
        state_s    = state_r;
        word_en_s  = 1'b0;
        addr_en_s  = 1'b0;
        addr_nxt_s = addr_r;
        rem_en_s   = 1'b0;
        rem_nxt_s  = rem_r;
        lane_en_s  = 1'b0;
        lane_nxt_s = lane_r;
        case (state_r)
            ST_IDLE: begin
                if (start_i) begin
                    if (len_i != LEN_ZERO) begin
                        state_s    = ST_READ;
                        addr_en_s  = 1'b1;
                        addr_nxt_s = base_addr_i;
                        rem_en_s   = 1'b1;
                        rem_nxt_s  = len_i;
                    end else begin
                        state_s = ST_DONE;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_READ: begin
                state_s = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                // Address advances here so the next READ needs no extra cycle.
                word_en_s  = 1'b1;
                lane_en_s  = 1'b1;
                lane_nxt_s = LANE_ZERO;
                addr_en_s  = 1'b1;
                addr_nxt_s = addr_r + ADDR_ONE;
                state_s    = ST_SERIAL;
            end
            ST_SERIAL: begin
                if (hs_s) begin
                    rem_en_s   = 1'b1;
                    rem_nxt_s  = rem_r - LEN_ONE;
                    lane_en_s  = 1'b1;
                    lane_nxt_s = lane_r + LANE_ONE;
                    if (rem_r == LEN_ONE) begin
                        state_s = ST_DONE;
                    end else if (lane_r == LANE_LAST) begin
                        state_s = ST_READ;
                    end else begin
                        state_s = ST_SERIAL;
                    end
                end else begin
                    state_s = ST_SERIAL;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    assign rem_d_s = rem_en_s ? rem_nxt_s : rem_r;

    // FSM state register.
    always_ff @(posedge clk_i) begin
        if (cke_i) begin
            if (rst_i) begin
                state_r <= ST_IDLE;
            end else begin
                state_r <= state_s;
            end
        end
    end

    // Control outputs registered from the next state so they track state_r.
    always_ff @(posedge clk_i) begin
        if (cke_i) begin
            if (rst_i) begin
                busy_o         <= 1'b0;
                done_o         <= 1'b0;
                ext_mem_r_en_o <= 1'b0;
                m_valid_o      <= 1'b0;
                m_last_o       <= 1'b0;
            end else begin
                busy_o         <= (state_s != ST_IDLE);
                done_o         <= (state_s == ST_DONE);
                ext_mem_r_en_o <= (state_s == ST_READ);
                m_valid_o      <= (state_s == ST_SERIAL);
                m_last_o       <= (state_s == ST_SERIAL) && (rem_d_s == LEN_ONE);
            end
        end
    end

    assign ext_mem_r_addr_o = addr_r;

    // Lane selection; big-endian mirrors the index since R is a power of two.
    always_comb begin
        if (BIG_ENDIAN != 0) begin
            lane_sel_s = lane_r ^ LANE_LAST;
        end else begin
            lane_sel_s = lane_r;
        end
        m_data_o = word_r[lane_sel_s*OUT_DATA_W +: OUT_DATA_W];
    end

endmodule

// File: tb/tb_iob_asym_mem_streamer.sv
// Scoreboard bench: little- and big-endian streamers share stimulus; expected
// beats and read addresses are queued from a memory model and popped on output.
module tb_iob_asym_mem_streamer;

    localparam int MW = 32;
    localparam int OW = 8;
    localparam int AW = 10;
    localparam int LW = 16;

    logic          clk = 1'b0;
    logic          cke, rst, start, ready;
    logic [AW-1:0] base;
    logic [LW-1:0] len;

    logic          busy_le, done_le, ren_le, val_le, last_le;
    logic [AW-1:0] raddr_le;
    logic [MW-1:0] rdata_le;
    logic [OW-1:0] data_le;
    logic          busy_be, done_be, ren_be, val_be, last_be;
    logic [AW-1:0] raddr_be;
    logic [MW-1:0] rdata_be;
    logic [OW-1:0] data_be;

    logic [MW-1:0] mem [0:(1<<AW)-1];

    typedef struct {
        logic [OW-1:0] le;
        logic [OW-1:0] be;
        logic          last;
    } beat_t;

    beat_t         beat_q[$];
    logic [AW-1:0] addr_q[$];
    int            vectors = 0;
    int            miscompares = 0;

    always #5 clk = ~clk;

    iob_asym_mem_streamer #(.MEM_DATA_W(MW), .OUT_DATA_W(OW), .ADDR_W(AW), .LEN_W(LW), .BIG_ENDIAN(0)) dut_le (
        .clk_i(clk), .cke_i(cke), .rst_i(rst), .start_i(start), .base_addr_i(base), .len_i(len),
        .busy_o(busy_le), .done_o(done_le), .ext_mem_r_en_o(ren_le), .ext_mem_r_addr_o(raddr_le),
        .ext_mem_r_data_i(rdata_le), .m_valid_o(val_le), .m_data_o(data_le), .m_last_o(last_le),
        .m_ready_i(ready)
    );

    iob_asym_mem_streamer #(.MEM_DATA_W(MW), .OUT_DATA_W(OW), .ADDR_W(AW), .LEN_W(LW), .BIG_ENDIAN(1)) dut_be (
        .clk_i(clk), .cke_i(cke), .rst_i(rst), .start_i(start), .base_addr_i(base), .len_i(len),
        .busy_o(busy_be), .done_o(done_be), .ext_mem_r_en_o(ren_be), .ext_mem_r_addr_o(raddr_be),
        .ext_mem_r_data_i(rdata_be), .m_valid_o(val_be), .m_data_o(data_be), .m_last_o(last_be),
        .m_ready_i(ready)
    );

    // Synchronous memory model, one-cycle read latency, same clock enable.
    always @(posedge clk) begin
        if (cke) begin
            if (ren_le) rdata_le <= mem[raddr_le];
            if (ren_be) rdata_be <= mem[raddr_be];
        end
    end

    task automatic test_reset();
        rst = 1'b1; cke = 1'b1; start = 1'b0; ready = 1'b0; base = '0; len = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        vectors++;
        if ({busy_le, done_le, ren_le, raddr_le, val_le, data_le, last_le} !== '0) begin
            miscompares++;
            $display("FAIL reset_le: got %h want 0", {busy_le, done_le, ren_le, raddr_le, val_le, data_le, last_le});
        end
        vectors++;
        if ({busy_be, done_be, ren_be, raddr_be, val_be, data_be, last_be} !== '0) begin
            miscompares++;
            $display("FAIL reset_be: got %h want 0", {busy_be, done_be, ren_be, raddr_be, val_be, data_be, last_be});
        end
        rst = 1'b0;
    endtask

    // One burst: queue expectations, start, then pop/compare every output cycle.
    task automatic run_burst(input logic [AW-1:0] b, input int n, input bit bp, input bit poke, input int abort_after);
        int            cyc, nbusy, hs, ndone, done_cyc, first_val, reads, words;
        bit            prev_pend;
        logic [OW-1:0] prev_le, prev_be;
        logic          prev_last;
        logic [AW-1:0] ea;
        logic [MW-1:0] w;
        beat_t         e;
        beat_q.delete(); addr_q.delete();
        words = (n + 3) / 4;
        for (int k = 0; k < words; k++) addr_q.push_back(AW'(int'(b) + k));
        for (int i = 0; i < n; i++) begin
            w      = mem[AW'(int'(b) + i / 4)];
            e.le   = w[(i % 4) * 8 +: 8];
            e.be   = w[(3 - (i % 4)) * 8 +: 8];
            e.last = (i == n - 1);
            beat_q.push_back(e);
        end
        cyc = 0; nbusy = 0; hs = 0; ndone = 0; done_cyc = -1; first_val = -1; reads = 0;
        prev_pend = 1'b0; prev_le = '0; prev_be = '0; prev_last = 1'b0;
        @(posedge clk); #1;
        start = 1'b1; base = b; len = LW'(n); cke = 1'b1; ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; base = '0; len = '0;
        forever begin
            cke   = bp ? ($urandom_range(0, 3) != 0) : 1'b1;
            ready = bp ? ($urandom_range(0, 1) == 1) : 1'b1;
            if (poke) begin
                start = (cyc == 4);
                base  = AW'(10'h200);
                len   = LW'(3);
            end
            if (abort_after > 0 && hs == abort_after) begin
                rst = 1'b1; cke = 1'b1; ready = 1'b0;
                @(posedge clk);
                @(negedge clk);
                vectors++;
                if ({busy_le, done_le, ren_le, raddr_le, val_le, data_le, last_le,
                     busy_be, done_be, ren_be, raddr_be, val_be, data_be, last_be} !== '0) begin
                    miscompares++;
                    $display("FAIL abort_outputs: got le=%h be=%h want 0",
                             {busy_le, done_le, ren_le, raddr_le, val_le, data_le, last_le},
                             {busy_be, done_be, ren_be, raddr_be, val_be, data_be, last_be});
                end
                rst = 1'b0;
                @(negedge clk);
                vectors++;
                if (done_le !== 1'b0 || busy_le !== 1'b0 || ndone != 0) begin
                    miscompares++;
                    $display("FAIL abort_no_done: done=%b busy=%b ndone=%0d want 0/0/0", done_le, busy_le, ndone);
                end
                beat_q.delete(); addr_q.delete();
                return;
            end
            @(negedge clk);
            if (busy_le !== 1'b1) break;
            nbusy++;
            if (prev_pend) begin
                vectors++;
                if (val_le !== 1'b1 || data_le !== prev_le || data_be !== prev_be || last_le !== prev_last) begin
                    miscompares++;
                    $display("FAIL stall_hold: got v=%b %h/%h l=%b want 1 %h/%h l=%b",
                             val_le, data_le, data_be, last_le, prev_le, prev_be, prev_last);
                end
            end
            if (ren_le === 1'b1 && cke) begin
                vectors++; reads++;
                if (addr_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL extra_read: got addr %h want no read", raddr_le);
                end else begin
                    ea = addr_q.pop_front();
                    if (raddr_le !== ea || raddr_be !== ea || ren_be !== 1'b1) begin
                        miscompares++;
                        $display("FAIL read_addr: got %h/%h want %h", raddr_le, raddr_be, ea);
                    end
                end
            end
            if (val_le === 1'b1 && first_val < 0) first_val = cyc;
            if (val_le === 1'b1 && ready && cke) begin
                vectors++; hs++;
                if (beat_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL extra_beat: got %h want none", data_le);
                end else begin
                    e = beat_q.pop_front();
                    if (data_le !== e.le || data_be !== e.be || last_le !== e.last || last_be !== e.last || val_be !== 1'b1) begin
                        miscompares++;
                        $display("FAIL beat: got le=%h be=%h last=%b/%b want le=%h be=%h last=%b",
                                 data_le, data_be, last_le, last_be, e.le, e.be, e.last);
                    end
                end
            end
            prev_pend = (val_le === 1'b1) && !(ready && cke);
            prev_le = data_le; prev_be = data_be; prev_last = last_le;
            if (done_le === 1'b1 && cke) begin
                ndone++; done_cyc = cyc;
            end
            @(posedge clk); #1;
            cyc++;
            if (cyc > 3000) begin
                vectors++; miscompares++;
                $display("FAIL timeout: got busy after %0d cycles want idle", cyc);
                break;
            end
        end
        start = 1'b0;
        vectors++;
        if (beat_q.size() != 0 || addr_q.size() != 0 || reads != words) begin
            miscompares++;
            $display("FAIL leftover: got beats_left=%0d reads=%0d want 0/%0d", beat_q.size(), reads, words);
        end
        vectors++;
        if (ndone != 1) begin
            miscompares++;
            $display("FAIL done_count: got %0d want 1", ndone);
        end
        if (!bp) begin
            vectors++;
            if (nbusy != n + 2 * words + 1 || done_cyc != nbusy - 1) begin
                miscompares++;
                $display("FAIL burst_timing: got busy=%0d done_at=%0d want busy=%0d done_at=%0d",
                         nbusy, done_cyc, n + 2 * words + 1, n + 2 * words);
            end
            if (n > 0) begin
                vectors++;
                if (first_val != 2) begin
                    miscompares++;
                    $display("FAIL first_valid: got cycle %0d want 2", first_val);
                end
            end
        end
    endtask

    task automatic test_full_words();
        mem[10'h010] = 32'h4433_2211;
        mem[10'h011] = 32'h8877_6655;
        run_burst(10'h010, 8, 1'b0, 1'b0, 0);
    endtask

    task automatic test_partial();
        run_burst(10'h010, 6, 1'b0, 1'b0, 0);
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 8; i++) mem[10'h020 + i] = $urandom;
        run_burst(10'h010, 8, 1'b1, 1'b0, 0);
        run_burst(10'h020, 29, 1'b1, 1'b0, 0);
    endtask

    task automatic test_wrap();
        mem[10'h3FF] = 32'hDDCC_BBAA;
        mem[10'h000] = 32'h0403_0201;
        run_burst(10'h3FF, 8, 1'b0, 1'b0, 0);
    endtask

    task automatic test_zero_len();
        run_burst(10'h155, 0, 1'b0, 1'b0, 0);
    endtask

    task automatic test_start_ignored();
        run_burst(10'h010, 8, 1'b0, 1'b1, 0);
    endtask

    task automatic test_mid_reset();
        run_burst(10'h010, 8, 1'b0, 1'b0, 3);
        run_burst(10'h010, 8, 1'b0, 1'b0, 0);
    endtask

    task automatic test_back_to_back();
        run_burst(10'h020, 5, 1'b0, 1'b0, 0);
        run_burst(10'h021, 12, 1'b0, 1'b0, 0);
    endtask

    initial begin
        test_reset();
        test_full_words();
        test_partial();
        test_backpressure();
        test_wrap();
        test_zero_len();
        test_start_ignored();
        test_mid_reset();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
